// File: rtl/memory_access.sv
// memory_access: MEM stage of the MIPS32 pipeline, producer of the 44-bit mem_wb packet.
//
// Accepts EX/MEM packets over a valid/ready handshake. LW (35) and SW (43) go through a
// variable-latency req/ack data-memory port; all other opcodes pass their ALU result straight
// through with one cycle of latency. Exactly one mem_wb word is produced per clock: either a
// completed instruction or a BUBBLE ({6'd43, 38'b0}). Opcode 43 keeps WB from writing a register.
//
// Ports:
//   clk, reset_n      clock; synchronous active-low reset
//   ex_valid/ex_mem   input packet {opcode[74:69], alu_result[68:37], store_data[36:5], dest[4:0]}
//   ex_ready          combinational, high only in IDLE and out of reset
//   dmem_req/we/addr/wdata   registered data-memory request, held stable while waiting
//   dmem_rdata/ack    data-memory response, sampled only while waiting
//   mem_wb            registered {opcode[43:38], wb_data[37:6], dest[5:1], is_load[0]}
//   mem_err           one-cycle pulse when an access is aborted
//
// Parameter TIMEOUT_CYCLES: wait cycles without ack before the access is aborted (0 = never).
// Optional macro MEM_ALIGN_CHECK_EN: misaligned LW/SW raise mem_err instead of issuing a request.

module memory_access #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ex_valid,
    input  logic [74:0] ex_mem,
    output logic        ex_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [43:0] mem_wb,
    output logic        mem_err
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);
    localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);

    localparam logic [5:0]  OpLw   = 6'd35;
    localparam logic [5:0]  OpSw   = 6'd43;
    localparam logic [43:0] Bubble = {6'd43, 38'b0};

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e          state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [5:0]      op_q, op_d;
    logic [4:0]      dest_q, dest_d;
    logic [43:0]     wb_q, wb_d;
    logic            err_q, err_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [5:0]      in_op;
    logic [31:0]     in_alu;
    logic [31:0]     in_sd;
    logic [4:0]      in_dest;
    logic            accept;
    logic            is_mem_op;
    logic            misaligned;
    logic [CntW-1:0] cnt_inc;
    logic            timeout_hit;

    assign in_op   = ex_mem[74:69];
    assign in_alu  = ex_mem[68:37];
    assign in_sd   = ex_mem[36:5];
    assign in_dest = ex_mem[4:0];

    assign ex_ready  = reset_n && (state_q == StIdle);
    assign accept    = ex_valid && ex_ready;
    assign is_mem_op = (in_op == OpLw) || (in_op == OpSw);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (in_alu[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign cnt_inc     = cnt_q + CntW'(1);
    // cnt_q counts completed ack-less wait cycles; this cycle is the last allowed one.
    assign timeout_hit = TimeoutEn && (cnt_inc == TimeoutVal);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        dest_d  = dest_q;
        wb_d    = Bubble;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (accept) begin
                    if (is_mem_op) begin
                        if (misaligned) begin
                            err_d = 1'b1;
                        end else begin
                            op_d    = in_op;
                            dest_d  = in_dest;
                            addr_d  = in_alu;
                            wdata_d = in_sd;
                            we_d    = (in_op == OpSw);
                            req_d   = 1'b1;
                            state_d = StWait;
                        end
                    end else begin
                        wb_d = {in_op, in_alu, in_dest, 1'b0};
                    end
                end
            end
            StWait: begin
                if (dmem_ack) begin
                    // Ack wins over a coincident timeout.
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (op_q == OpLw) begin
                        wb_d = {OpLw, dmem_rdata, dest_q, 1'b1};
                    end else begin
                        wb_d = {OpSw, wdata_q, dest_q, 1'b0};
                    end
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (cnt_q != '1) begin
                    // Saturate rather than wrap when timeouts are disabled.
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= '0;
            dest_q  <= '0;
            wb_q    <= Bubble;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            dest_q  <= dest_d;
            wb_q    <= wb_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign mem_wb     = wb_q;
    assign mem_err    = err_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed testbench for memory_access (TIMEOUT_CYCLES = 16). Expectations are hand-computed
// constants; the misaligned-access vector follows MEM_ALIGN_CHECK_EN if it is defined.

module tb_memory_access;

    localparam logic [43:0] Bubble = {6'd43, 38'b0};

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_valid;
    logic [74:0] ex_mem;
    logic        ex_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic [43:0] mem_wb;
    logic        mem_err;

    int n_vec = 0;
    int n_err = 0;

    memory_access #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ex_valid   (ex_valid),
        .ex_mem     (ex_mem),
        .ex_ready   (ex_ready),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .mem_wb     (mem_wb),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [4:0] dest);
        ex_mem   = {op, alu, sd, dest};
        ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
    endtask

    initial begin
        int  n;
        bit  err_seen;

        reset_n    = 1'b0;
        ex_valid   = 1'b0;
        ex_mem     = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        tick();
        tick();
        check_val("rst_mem_wb", mem_wb, Bubble);
        check_val("rst_req", dmem_req, 0);
        check_val("rst_err", mem_err, 0);
        check_val("rst_addr", dmem_addr, 0);
        check_val("rst_ready_low", ex_ready, 0);
        reset_n = 1'b1;
        #1;
        check_val("ready_after_rst", ex_ready, 1);

        // ALU pass-through, latency 1
        send(6'd0, 32'h0000_1234, 32'h0, 5'd5);
        check_val("alu_wb", mem_wb, {6'd0, 32'h0000_1234, 5'd5, 1'b0});
        check_val("alu_no_req", dmem_req, 0);
        check_val("alu_ready", ex_ready, 1);
        tick();
        check_val("alu_then_bubble", mem_wb, Bubble);

        // Ack while idle is ignored
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5555_5555;
        tick();
        dmem_ack = 1'b0;
        check_val("idle_ack_wb", mem_wb, Bubble);
        check_val("idle_ack_req", dmem_req, 0);

        // LW, ack in the 4th wait cycle
        send(6'd35, 32'h0000_0100, 32'h0, 5'd8);
        check_val("lw_we", dmem_we, 0);
        for (int i = 0; i < 3; i++) begin
            check_val("lw_req_hold", dmem_req, 1);
            check_val("lw_addr_hold", dmem_addr, 32'h100);
            check_val("lw_ready_low", ex_ready, 0);
            check_val("lw_bubble", mem_wb, Bubble);
            tick();
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        check_val("lw_ack_ready_low", ex_ready, 0);
        tick();
        dmem_ack = 1'b0;
        check_val("lw_wb", mem_wb, {6'd35, 32'hDEAD_BEEF, 5'd8, 1'b1});
        check_val("lw_req_drop", dmem_req, 0);
        check_val("lw_ready_back", ex_ready, 1);

        // SW with immediate ack; ALU op offered during the ack cycle
        send(6'd43, 32'h0000_0040, 32'h0000_CAFE, 5'd3);
        check_val("sw_we", dmem_we, 1);
        check_val("sw_wdata", dmem_wdata, 32'h0000_CAFE);
        check_val("sw_addr", dmem_addr, 32'h40);
        check_val("sw_req", dmem_req, 1);
        dmem_ack = 1'b1;
        ex_mem   = {6'd4, 32'h0000_0055, 32'h0, 5'd9};
        ex_valid = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check_val("sw_wb", mem_wb, {6'd43, 32'h0000_CAFE, 5'd3, 1'b0});
        check_val("sw_req_drop", dmem_req, 0);
        check_val("sw_ready_back", ex_ready, 1);
        tick();
        ex_valid = 1'b0;
        check_val("b2b_alu_wb", mem_wb, {6'd4, 32'h0000_0055, 5'd9, 1'b0});

        // LW with no ack: abort after 16 wait cycles
        send(6'd35, 32'h0000_0200, 32'h0, 5'd2);
        n        = 0;
        err_seen = 1'b0;
        while (dmem_req && n < 40) begin
            if (mem_err) err_seen = 1'b1;
            n++;
            tick();
        end
        check_val("to_wait_len", n, 16);
        check_val("to_no_early_err", err_seen, 0);
        check_val("to_err", mem_err, 1);
        check_val("to_wb", mem_wb, Bubble);
        check_val("to_ready", ex_ready, 1);
        tick();
        check_val("to_err_pulse", mem_err, 0);

        // Ack in the 16th wait cycle wins over the timeout
        send(6'd35, 32'h0000_0300, 32'h0, 5'd6);
        for (int i = 0; i < 15; i++) tick();
        check_val("race_req", dmem_req, 1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0BAD_F00D;
        tick();
        dmem_ack = 1'b0;
        check_val("race_no_err", mem_err, 0);
        check_val("race_wb", mem_wb, {6'd35, 32'h0BAD_F00D, 5'd6, 1'b1});

        // Reset mid-wait abandons the access
        send(6'd35, 32'h0000_0400, 32'h0, 5'd7);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_val("rstw_req", dmem_req, 0);
        check_val("rstw_wb", mem_wb, Bubble);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_1111;
        tick();
        dmem_ack = 1'b0;
        check_val("rstw_late_ack_wb", mem_wb, Bubble);
        check_val("rstw_late_ack_req", dmem_req, 0);

        // Misaligned LW
        send(6'd35, 32'h0000_0102, 32'h0, 5'd4);
`ifdef MEM_ALIGN_CHECK_EN
        check_val("mis_no_req", dmem_req, 0);
        check_val("mis_err", mem_err, 1);
        check_val("mis_wb", mem_wb, Bubble);
        check_val("mis_ready", ex_ready, 1);
`else
        check_val("mis_req", dmem_req, 1);
        check_val("mis_addr", dmem_addr, 32'h102);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h2222_2222;
        tick();
        dmem_ack = 1'b0;
        check_val("mis_wb", mem_wb, {6'd35, 32'h2222_2222, 5'd4, 1'b1});
        check_val("mis_no_err", mem_err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
